text_buffer_writer: RTL and testbench

//  Character-cell writer feeding the text renderer: accepts a byte stream (keyboard/UART),

---
 rtl/text_buffer_writer.sv | 184 ++++++++++++++++++
 tb/tb_text_buffer_writer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_buffer_writer.sv
// Character-cell writer: stores a byte stream into a COLS x ROWS text RAM and serves it to the renderer.
// Latency: accepted byte -> RAM and cursor on the next edge; (x,y) -> ascii_code one cycle later.
// Backpressure: rx_ready is low while the RAM is being cleared (after reset or ESC), high in IDLE.
//
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   rx_data/valid/ready     byte stream in, valid/ready handshake
//   x, y                    current pixel from the VGA sync block
//   ascii_code              registered code of the cell under (x,y); bit 7 selects the Thai glyph ROM
//   cursor_col, cursor_row  current write cursor
module text_buffer_writer #(
  parameter int COLS       = 32,         // power of two
  parameter int ROWS       = 4,          // power of two
  parameter int X0         = 192,
  parameter int Y0         = 208,
  parameter int BLINK_HALF = 25_000_000  // at least 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  input  logic [9:0]              x,
  input  logic [9:0]              y,
  output logic [7:0]              ascii_code,
  output logic [$clog2(COLS)-1:0] cursor_col,
  output logic [$clog2(ROWS)-1:0] cursor_row
);

  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int AW    = CW + RW;
  localparam int CELLS = COLS * ROWS;
  localparam int BW    = $clog2(BLINK_HALF);

  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
  localparam logic [AW-1:0] ADDR_LAST  = AW'(CELLS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  localparam logic [9:0] X_LO = 10'(X0);
  localparam logic [9:0] X_HI = 10'(X0 + 8 * COLS);
  localparam logic [9:0] Y_LO = 10'(Y0);
  localparam logic [9:0] Y_HI = 10'(Y0 + 16 * ROWS);

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_UNDER = 8'h5F;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_ESC   = 8'h1B;
  localparam logic [7:0] CH_DEL   = 8'h7F;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t        state;
  logic [AW-1:0] clr_addr;
  logic [7:0]    mem [CELLS];

  logic          accept;
  logic          printable;
  logic [CW-1:0] nxt_col;
  logic [RW-1:0] nxt_row;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_dat;

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  logic          in_win;
  logic [CW-1:0] rd_col;
  logic [RW-1:0] rd_row;
  logic          cursor_hit;

  assign accept    = rx_valid && rx_ready;
  assign printable = (rx_data >= CH_SPACE) && (rx_data != CH_DEL);

  // Write port and next cursor. Clearing owns the write port; otherwise the
  // accepted byte decides. Backspace writes the blank at the *new* position.
  always_comb begin
    nxt_col = cursor_col;
    nxt_row = cursor_row;
    wr_en   = 1'b0;
    wr_addr = {cursor_row, cursor_col};
    wr_dat  = CH_SPACE;
    if (state == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
    end else if (accept) begin
      if (printable) begin
        wr_en  = 1'b1;
        wr_dat = rx_data;
        if (cursor_col == COL_LAST) begin
          nxt_col = '0;
          nxt_row = (cursor_row == ROW_LAST) ? '0 : cursor_row + 1'b1;
        end else begin
          nxt_col = cursor_col + 1'b1;
        end
      end else if (rx_data == CH_BS) begin
        if (cursor_col != '0) begin
          nxt_col = cursor_col - 1'b1;
          wr_en   = 1'b1;
        end else if (cursor_row != '0) begin
          nxt_col = COL_LAST;
          nxt_row = cursor_row - 1'b1;
          wr_en   = 1'b1;
        end
        wr_addr = {nxt_row, nxt_col};
      end else if (rx_data == CH_CR) begin
        nxt_col = '0;
        nxt_row = (cursor_row == ROW_LAST) ? '0 : cursor_row + 1'b1;
      end else if (rx_data == CH_ESC) begin
        nxt_col = '0;
        nxt_row = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR;
      clr_addr   <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
      rx_ready   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == ADDR_LAST) begin
            state    <= IDLE;
            rx_ready <= 1'b1;
          end
        end
        IDLE: begin
          cursor_col <= nxt_col;
          cursor_row <= nxt_row;
          if (accept && rx_data == CH_ESC) begin
            state    <= CLEAR;
            clr_addr <= '0;
            rx_ready <= 1'b0;
          end
        end
        default: begin
          state    <= CLEAR;
          clr_addr <= '0;
          rx_ready <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Read side. The slices are only meaningful inside the window, which gates them.
  assign in_win     = (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);
  assign rd_col     = CW'((x - X_LO) >> 3);
  assign rd_row     = RW'((y - Y_LO) >> 4);
  assign cursor_hit = blink_phase && (state == IDLE) &&
                      (rd_col == cursor_col) && (rd_row == cursor_row);

  // Separate RAM process; the read below sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (reset)           ascii_code <= CH_SPACE;
    else if (!in_win)    ascii_code <= CH_SPACE;
    else if (cursor_hit) ascii_code <= CH_UNDER;
    else                 ascii_code <= mem[{rd_row, rd_col}];
  end

endmodule

// File: tb/tb_text_buffer_writer.sv
// Directed bench for text_buffer_writer: table of single-byte vectors plus
// hand-written sequences for clear timing, wrap, ESC mid-stream and blink.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_text_buffer_writer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [9:0] x = 10'd0;
  logic [9:0] y = 10'd0;
  logic [7:0] ascii_code;
  logic [4:0] cursor_col;
  logic [1:0] cursor_row;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  text_buffer_writer #(
    .COLS(32), .ROWS(4), .X0(192), .Y0(208), .BLINK_HALF(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .x          (x),
    .y          (y),
    .ascii_code (ascii_code),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  typedef struct {
    logic [7:0] b;
    int         ecol;
    int         erow;
    int         ccol;
    int         crow;
    logic [7:0] cval;
  } vec_t;

  vec_t tbl [0:20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int t = 0;
    while (!rx_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: rx_ready still 0 after %0d cycles, want 1", name, t);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    wait_ready("send_ready");
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Counts falling edges with rx_ready low, starting with the current one.
  task automatic count_low(output int n);
    n = 0;
    while (!rx_ready && n < 400) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Point (x,y) somewhere inside the cell; skip over blink-underscore samples.
  task automatic read_cell(input int c, input int r, output logic [7:0] v);
    x = 10'(192 + 8 * c + (c % 8));
    y = 10'(208 + 16 * r + ((r * 5) % 16));
    v = 8'h00;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      v = ascii_code;
      if (v != 8'h5F) break;
    end
  endtask

  task automatic check_cell(input string name, input int c, input int r, input logic [7:0] e);
    logic [7:0] v;
    read_cell(c, r, v);
    check(name, 32'(v), 32'(e));
  endtask

  task automatic scan_all(input string name, input logic [7:0] first_val);
    logic [7:0] v;
    logic [7:0] e;
    int bad = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 32; c++) begin
        read_cell(c, r, v);
        e = (r == 0 && c == 0) ? first_val : 8'h20;
        if (v !== e) bad++;
      end
    end
    check(name, 32'(bad), 32'd0);
  endtask

  function automatic logic [7:0] fill_byte(input int i);
    return 8'(8'h21 + (i % 90));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s [0:23];
    logic [7:0] a;
    logic [7:0] b;
    int n;
    int t0;
    int odd;

    tbl[0]  = '{8'h1B,  0, 0,  0, 0, 8'h20};
    tbl[1]  = '{8'h08,  0, 0,  0, 0, 8'h20};
    tbl[2]  = '{8'h41,  1, 0,  0, 0, 8'h41};
    tbl[3]  = '{8'h08,  0, 0,  0, 0, 8'h20};
    tbl[4]  = '{8'h07,  0, 0,  1, 0, 8'h20};
    tbl[5]  = '{8'h7F,  0, 0,  0, 0, 8'h20};
    tbl[6]  = '{8'h00,  0, 0,  0, 0, 8'h20};
    tbl[7]  = '{8'h42,  1, 0,  0, 0, 8'h42};
    tbl[8]  = '{8'hC3,  2, 0,  1, 0, 8'hC3};
    tbl[9]  = '{8'h0D,  0, 1,  2, 0, 8'h20};
    tbl[10] = '{8'h08, 31, 0, 31, 0, 8'h20};
    tbl[11] = '{8'h44,  0, 1, 31, 0, 8'h44};
    tbl[12] = '{8'h0D,  0, 2,  0, 1, 8'h20};
    tbl[13] = '{8'h0D,  0, 3,  0, 2, 8'h20};
    tbl[14] = '{8'h45,  1, 3,  0, 3, 8'h45};
    tbl[15] = '{8'h45,  2, 3,  1, 3, 8'h45};
    tbl[16] = '{8'h45,  3, 3,  2, 3, 8'h45};
    tbl[17] = '{8'h45,  4, 3,  3, 3, 8'h45};
    tbl[18] = '{8'h45,  5, 3,  4, 3, 8'h45};
    tbl[19] = '{8'h0D,  0, 0,  4, 3, 8'h45};
    tbl[20] = '{8'h0D,  0, 1,  0, 0, 8'h42};

    // Reset state and clear length
    do_reset();
    check("rst_ready", 32'(rx_ready), 32'd0);
    check("rst_ascii", 32'(ascii_code), 32'h20);
    check("rst_col", 32'(cursor_col), 32'd0);
    check("rst_row", 32'(cursor_row), 32'd0);
    count_low(n);
    check("clear_len", 32'(n), 32'd128);
    scan_all("clear_all", 8'h20);

    // 'H','I' back-to-back, then read latency
    wait_ready("hi_ready");
    rx_data = 8'h48; rx_valid = 1'b1;
    @(negedge clk);
    check("hi_ready_b2b", 32'(rx_ready), 32'd1);
    rx_data = 8'h49;
    @(negedge clk);
    rx_valid = 1'b0;
    check("hi_col", 32'(cursor_col), 32'd2);
    check("hi_row", 32'(cursor_row), 32'd0);
    check_cell("hi_cell1", 1, 0, 8'h49);
    x = 10'd192; y = 10'd208;
    #1;
    check("lat_hold", 32'(ascii_code), 32'h49);
    @(negedge clk);
    check("lat_one", 32'(ascii_code), 32'h48);

    // Byte-by-byte vectors
    for (int i = 0; i < 21; i++) begin
      send_byte(tbl[i].b);
      check($sformatf("vec%0d_col", i), 32'(cursor_col), 32'(tbl[i].ecol));
      check($sformatf("vec%0d_row", i), 32'(cursor_row), 32'(tbl[i].erow));
      wait_ready($sformatf("vec%0d_ready", i));
      check_cell($sformatf("vec%0d_cell", i), tbl[i].ccol, tbl[i].crow, tbl[i].cval);
    end

    // 128 printable bytes wrap the cursor, then a Thai code lands at (0,0)
    send_byte(8'h1B);
    wait_ready("wrap_ready");
    rx_valid = 1'b1;
    for (int i = 0; i < 128; i++) begin
      rx_data = fill_byte(i);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    check("wrap_col", 32'(cursor_col), 32'd0);
    check("wrap_row", 32'(cursor_row), 32'd0);
    send_byte(8'hA1);
    check("thai_col", 32'(cursor_col), 32'd1);
    check("thai_row", 32'(cursor_row), 32'd0);
    check_cell("thai_cell", 0, 0, 8'hA1);
    check("thai_bit7", 32'(ascii_code[7]), 32'd1);
    check_cell("wrap_cell1", 1, 0, fill_byte(1));
    check_cell("wrap_cell127", 31, 3, fill_byte(127));

    // Window edges
    x = 10'd447; y = 10'd271; @(negedge clk);
    check("edge_in_br", 32'(ascii_code), 32'(fill_byte(127)));
    x = 10'd448; y = 10'd271; @(negedge clk);
    check("edge_out_x", 32'(ascii_code), 32'h20);
    x = 10'd447; y = 10'd272; @(negedge clk);
    check("edge_out_y", 32'(ascii_code), 32'h20);
    x = 10'd191; y = 10'd208; @(negedge clk);
    check("edge_out_left", 32'(ascii_code), 32'h20);
    x = 10'd192; y = 10'd208; @(negedge clk);
    check("edge_in_tl", 32'(ascii_code), 32'hA1);

    // ESC mid-stream with the next byte held valid through the clear
    rx_valid = 1'b1;
    rx_data = 8'h58; @(negedge clk);
    rx_data = 8'h59; @(negedge clk);
    rx_data = 8'h1B; @(negedge clk);
    rx_data = 8'h5A;
    count_low(n);
    check("esc_len", 32'(n), 32'd128);
    @(negedge clk);
    rx_valid = 1'b0;
    check("esc_col", 32'(cursor_col), 32'd1);
    check("esc_row", 32'(cursor_row), 32'd0);
    scan_all("esc_clear", 8'h5A);

    // Cursor blink at (3,1)
    send_byte(8'h0D);
    send_byte(8'h61);
    send_byte(8'h62);
    send_byte(8'h63);
    check("blink_col", 32'(cursor_col), 32'd3);
    check("blink_row", 32'(cursor_row), 32'd1);
    x = 10'd216; y = 10'd224;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      s[k] = ascii_code;
    end
    t0 = 0;
    for (int k = 1; k < 6; k++) begin
      if (t0 == 0 && s[k] != s[k-1]) t0 = k;
    end
    if (t0 == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL blink_toggle: got constant 0x%0h for 6 cycles, want a change", s[0]);
    end else begin
      a = s[t0];
      check("blink_val", 32'(a == 8'h5F || a == 8'h20), 32'd1);
      b = (a == 8'h5F) ? 8'h20 : 8'h5F;
      for (int j = 0; j < 16; j++) begin
        check($sformatf("blink%0d", j), 32'(s[t0 + j]), 32'(((j / 4) % 2 == 0) ? a : b));
      end
    end
    x = 10'd100;
    odd = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ascii_code != 8'h20) odd++;
    end
    check("out_x100", 32'(odd), 32'd0);

    // Reset in the middle of a clear restarts it from address 0
    do_reset();
    repeat (40) @(negedge clk);
    do_reset();
    check("rst2_col", 32'(cursor_col), 32'd0);
    check("rst2_row", 32'(cursor_row), 32'd0);
    count_low(n);
    check("rst2_len", 32'(n), 32'd128);
    scan_all("rst2_clear", 8'h20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
